cache_ctrl: RTL

- Direct-mapped, one-word-per-line, write-through, no-write-allocate controller for the data cache of the RV32I pipeline.
- Sits between the MEM stage (cpu_* port) and the memory bus (mem_* port).
- Drives the cache data SRAM through the sram_* port. The SRAM read is combinational, the write is synchronous, and its contents are not reset.
- Owns the tag and valid arrays and the miss/refill/write-through state machine.

---
 rtl/cache_pkg.sv | 23 ++
 rtl/cache_tag_array.sv | 38 +++
 rtl/cache_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the direct-mapped data cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_t;

    localparam int DEF_DEPTH = 16;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_AW    = 32;

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

    // Byte offset is two bits: one word per line.
    function automatic int tag_w(input int aw, input int depth);
        return aw - $clog2(depth) - 2;
    endfunction

endpackage

// File: rtl/cache_tag_array.sv
// Tag and valid storage: combinational read, synchronous write and clear.
module cache_tag_array
    import cache_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int TW    = tag_w(DEF_AW, DEF_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [TW-1:0]            rd_tag,
    output logic                     rd_valid,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [TW-1:0]            wr_tag
);

    logic [DEPTH-1:0] valid;
    logic [TW-1:0]    tags [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
        end
    end

    assign rd_tag   = tags[rd_idx];
    assign rd_valid = valid[rd_idx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [AW-1:0]            cpu_addr,
    input  logic [WIDTH-1:0]         cpu_wdata,
    output logic [WIDTH-1:0]         cpu_rdata,
    output logic                     cpu_ready,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [WIDTH-1:0]         mem_rdata,
    input  logic                     mem_ack,
    output logic [$clog2(DEPTH)-1:0] sram_addr,
    output logic [WIDTH-1:0]         sram_wdata,
    output logic                     sram_we,
    input  logic [WIDTH-1:0]         sram_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]              stat_hits,
    output logic [31:0]              stat_misses
`endif
);

    localparam int IDX = idx_w(DEPTH);
    localparam int TW  = tag_w(AW, DEPTH);

    state_t          state;
    logic [IDX-1:0]  index;
    logic [TW-1:0]   tag;
    logic [TW-1:0]   line_tag;
    logic            line_valid;
    logic            hit;
    logic            tag_we;
    logic [AW-1:0]   line_addr;
    logic            unused_bits;

    assign index       = cpu_addr[IDX+1:2];
    assign tag         = cpu_addr[AW-1:IDX+2];
    assign line_addr   = {cpu_addr[AW-1:2], 2'b00};
    assign hit         = line_valid && (line_tag == tag);
    assign unused_bits = ^cpu_addr[1:0];

    cache_tag_array #(
        .DEPTH (DEPTH),
        .TW    (TW)
    ) u_tags (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (index),
        .rd_tag   (line_tag),
        .rd_valid (line_valid),
        .wr_en    (tag_we),
        .wr_idx   (index),
        .wr_tag   (tag)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu_req && cpu_we) begin
                        state <= WR_THRU;
                    end else if (cpu_req && !hit) begin
                        state <= RD_MISS;
                    end
                end
                RD_MISS: if (mem_ack) state <= IDLE;
                WR_THRU: if (mem_ack) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cpu_ready  = 1'b0;
        cpu_rdata  = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        sram_addr  = index;
        sram_we    = 1'b0;
        sram_wdata = '0;
        tag_we     = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_req && cpu_we && hit) begin
                    sram_we    = 1'b1;
                    sram_wdata = cpu_wdata;
                end else if (cpu_req && !cpu_we && hit) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = sram_rdata;
                end
            end
            RD_MISS: begin
                mem_req  = 1'b1;
                mem_addr = line_addr;
                if (mem_ack) begin
                    cpu_ready  = 1'b1;
                    cpu_rdata  = mem_rdata;
                    sram_we    = 1'b1;
                    sram_wdata = mem_rdata;
                    tag_we     = 1'b1;
                end
            end
            WR_THRU: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = line_addr;
                mem_wdata = cpu_wdata;
                cpu_ready = mem_ack;
            end
            default: ;
        endcase
        // Nothing may complete or write while reset is asserted.
        if (!rst_n) begin
            cpu_ready = 1'b0;
            sram_we   = 1'b0;
            tag_we    = 1'b0;
        end
    end

`ifdef CACHE_STATS_EN
    logic idle_req;

    assign idle_req = (state == IDLE) && cpu_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (idle_req) begin
            if (hit && stat_hits != 32'hFFFF_FFFF) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (!hit && stat_misses != 32'hFFFF_FFFF) begin
                stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`endif

endmodule
